// File: rtl/spi_pkg.sv
// Shared SPI definitions used by spi_master and its clock generator.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  // Mode 0: sclk idles low, data sampled on the rising sclk edge.
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period divider for the SPI master. The counter runs whenever the
// master is busy and wraps every CLK_DIV cycles (half_tc). sclk only
// toggles while sclk_en is high; otherwise it is held at its idle level.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cnt_en,
  input  logic sclk_en,
  output logic half_tc,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  assign half_tc   = cnt_en && (cnt_q == CNT_LAST);
  assign rise_tick = sclk_en && half_tc && (sclk_q == SPI_CPOL);
  assign fall_tick = sclk_en && half_tc && (sclk_q != SPI_CPOL);
  assign sclk      = sclk_q;

  // Next counter value and next sclk level; counter parks at 0 when idle.
  always_comb begin
    cnt_d = '0;
    if (cnt_en && !half_tc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    sclk_d = SPI_CPOL;
    if (sclk_en) begin
      sclk_d = half_tc ? ~sclk_q : sclk_q;
    end
  end

  // Divider counter and registered sclk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      sclk_q <= SPI_CPOL;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: shifts one DATA_W-bit word out on mosi while
// capturing miso, with a start/busy/done handshake toward the controller.
//
//   state | meaning
//   IDLE  | ss high, waiting for start
//   SETUP | ss low, first mosi bit presented, sclk low for CLK_DIV cycles
//   XFER  | 2*DATA_W sclk half-periods; sample miso on rise, shift mosi on fall
//   HOLD  | ss still low, sclk low for CLK_DIV cycles before releasing ss
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              ss,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  spi_state_t        state_q, state_d;
  logic              ss_q, ss_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mosi_q, mosi_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;

  logic half_tc, rise_tick, fall_tick;

  function automatic logic out_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .cnt_en    (state_q != IDLE),
    .sclk_en   (state_q == XFER),
    .half_tc   (half_tc),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .sclk      (sclk)
  );

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    ss_d      = ss_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mosi_d    = mosi_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mosi_d    = out_bit(tx_data);
          tx_sh_d   = shift_out(tx_data);
          rx_sh_d   = '0;
          bit_cnt_d = '0;
          ss_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (half_tc) state_d = XFER;
      end
      XFER: begin
        if (rise_tick) rx_sh_d = shift_in(rx_sh_q, miso);
        if (fall_tick) begin
          // The final fall ends the word; mosi keeps its last bit into HOLD.
          if (bit_cnt_q == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            mosi_d    = out_bit(tx_sh_q);
            tx_sh_d   = shift_out(tx_sh_q);
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      HOLD: begin
        if (half_tc) begin
          ss_d      = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          mosi_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, shift registers and registered pin/handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ss_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mosi_q    <= 1'b0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mosi_q    <= mosi_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign ss      = ss_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: default instance (CLK_DIV=4, MSB first) plus a
// fast LSB-first instance (CLK_DIV=1, MSB_FIRST=0) in loopback.
module tb_spi_master;

  localparam int DW   = 8;
  localparam int DIV0 = 4;
  localparam int DIV1 = 1;
  localparam int LAT0 = DIV0 * (2 * DW + 2);
  localparam int LAT1 = DIV1 * (2 * DW + 2);

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0 (defaults)
  logic          rst0_n, start0, miso_drv0, loop0;
  logic [DW-1:0] tx0;
  logic          busy0, done0, ss0, sclk0, mosi0, miso0;
  logic [DW-1:0] rx0;
  assign miso0 = loop0 ? mosi0 : miso_drv0;

  spi_master dut0 (
    .clk(clk), .reset_n(rst0_n), .start(start0), .tx_data(tx0),
    .busy(busy0), .done(done0), .rx_data(rx0),
    .ss(ss0), .sclk(sclk0), .mosi(mosi0), .miso(miso0)
  );

  // Instance 1 (CLK_DIV=1, LSB first, loopback)
  logic          rst1_n, start1;
  logic [DW-1:0] tx1;
  logic          busy1, done1, ss1, sclk1, mosi1;
  logic [DW-1:0] rx1;

  spi_master #(.DATA_W(DW), .CLK_DIV(DIV1), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset_n(rst1_n), .start(start1), .tx_data(tx1),
    .busy(busy1), .done(done1), .rx_data(rx1),
    .ss(ss1), .sclk(sclk1), .mosi(mosi1), .miso(mosi1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the i-th bit on the wire of word w.
  function automatic logic bit_at(input logic [DW-1:0] w, input int i, input bit msb_first);
    return msb_first ? w[DW-1-i] : w[i];
  endfunction

  typedef struct {
    logic [DW-1:0] tx;
    logic [DW-1:0] mw;
    bit            loop;
    logic [DW-1:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  // One transfer on instance 0; miso follows word mw (or loopback).
  task automatic xfer0(input logic [DW-1:0] tx, input logic [DW-1:0] mw, input bit loop,
                       input logic [DW-1:0] exp_rx, input string nm, input bit poke);
    int cyc, rises, falls, ss_bad, done_cnt, post_bad;
    logic [DW-1:0] cap;
    logic prev;
    @(negedge clk);
    loop0 = loop; tx0 = tx; miso_drv0 = bit_at(mw, 0, 1'b1); start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0; tx0 = DW'($urandom);
    check({nm, "_accept"}, {ss0, busy0}, 2'b01);
    cyc = 0; rises = 0; falls = 0; ss_bad = 0; done_cnt = 0; cap = '0; prev = sclk0;
    while (done_cnt == 0 && cyc < LAT0 + 20) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 20) begin start0 = 1'b1; tx0 = 8'hFF; end
      if (poke && cyc == 21) start0 = 1'b0;
      if (sclk0 && !prev) begin
        if (rises < DW) cap[DW-1-rises] = mosi0;
        rises++;
      end
      if (!sclk0 && prev) begin
        falls++;
        if (falls < DW) miso_drv0 = bit_at(mw, falls, 1'b1);
      end
      prev = sclk0;
      if (done0) done_cnt++;
      else if (ss0 || !busy0) ss_bad++;
    end
    check({nm, "_done_seen"}, done_cnt, 1);
    check({nm, "_latency"}, cyc, LAT0);
    check({nm, "_rx"}, rx0, exp_rx);
    check({nm, "_mosi_seq"}, cap, tx);
    check({nm, "_rises"}, rises, DW);
    check({nm, "_ss_window"}, ss_bad, 0);
    check({nm, "_end_pins"}, {ss0, busy0, sclk0, mosi0}, 4'b1000);
    post_bad = 0;
    repeat (DIV0 * 6) begin
      @(negedge clk);
      if (done0 || busy0 || !ss0) post_bad++;
    end
    check({nm, "_quiet_after"}, post_bad, 0);
  endtask

  // One loopback transfer on instance 1 (LSB first).
  task automatic xfer1(input logic [DW-1:0] tx, input string nm);
    int cyc, rises;
    logic [DW-1:0] cap;
    logic prev;
    @(negedge clk);
    tx1 = tx; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; tx1 = DW'($urandom);
    check({nm, "_first_bit"}, mosi1, bit_at(tx, 0, 1'b0));
    cyc = 0; rises = 0; cap = '0; prev = sclk1;
    while (!done1 && cyc < LAT1 + 20) begin
      @(negedge clk);
      cyc++;
      if (sclk1 && !prev) begin
        if (rises < DW) cap[rises] = mosi1;
        rises++;
      end
      prev = sclk1;
    end
    check({nm, "_latency"}, cyc, LAT1);
    check({nm, "_rx"}, rx1, tx);
    check({nm, "_mosi_seq"}, cap, tx);
    check({nm, "_rises"}, rises, DW);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2, cyc, ss_hi, dn;
    logic [DW-1:0] r_tx, r_mw;

    vecs[0] = '{tx: 8'hA5, mw: 8'h00, loop: 1'b1, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'h3C, mw: 8'hFF, loop: 1'b0, exp_rx: 8'hFF};
    vecs[2] = '{tx: 8'h00, mw: 8'h00, loop: 1'b1, exp_rx: 8'h00};
    vecs[3] = '{tx: 8'hFF, mw: 8'h00, loop: 1'b0, exp_rx: 8'h00};
    vecs[4] = '{tx: 8'h5A, mw: 8'hC3, loop: 1'b0, exp_rx: 8'hC3};

    rst0_n = 1'b0; rst1_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    tx0 = '0; tx1 = '0; miso_drv0 = 1'b0; loop0 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pins0", {ss0, sclk0, mosi0, busy0, done0}, 5'b10000);
    check("reset_rx0", rx0, 8'h00);
    check("reset_pins1", {ss1, sclk1, mosi1, busy1, done1}, 5'b10000);
    rst0_n = 1'b1; rst1_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++)
      xfer0(vecs[i].tx, vecs[i].mw, vecs[i].loop, vecs[i].exp_rx, $sformatf("vec%0d", i), 1'b0);

    for (int i = 0; i < 4; i++) begin
      r_tx = DW'($urandom);
      r_mw = DW'($urandom);
      xfer0(r_tx, r_mw, 1'b0, r_mw, $sformatf("rand%0d", i), 1'b0);
    end

    xfer0(8'h69, 8'h00, 1'b1, 8'h69, "ignore_start", 1'b1);

    // Back-to-back: start held high across done.
    @(negedge clk);
    loop0 = 1'b1; tx0 = 8'h12; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx0 = 8'h34; cyc = 0; d1 = -1; d2 = -1; ss_hi = 0;
    while (d2 < 0 && cyc < 2 * LAT0 + 40) begin
      @(negedge clk);
      cyc++;
      if (d1 >= 0 && cyc == d1 + 1) begin
        start0 = 1'b0; tx0 = 8'hEE;
        check("b2b_reaccept", {ss0, busy0}, 2'b01);
      end
      if (ss0 && !(done0 && d1 >= 0)) ss_hi++;
      if (done0) begin
        if (d1 < 0) begin
          d1 = cyc;
          check("b2b_rx1", rx0, 8'h12);
        end else begin
          d2 = cyc;
          check("b2b_rx2", rx0, 8'h34);
        end
      end
    end
    start0 = 1'b0;
    check("b2b_first_latency", d1, LAT0);
    check("b2b_gap", d2 - d1, LAT0 + 1);
    check("b2b_ss_high", ss_hi, 1);
    repeat (8) @(negedge clk);

    // Reset in the middle of a transfer.
    @(negedge clk);
    loop0 = 1'b1; tx0 = 8'h5D; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_reset_busy", {ss0, busy0, mosi0}, 3'b011);
    rst0_n = 1'b0;
    #1;
    check("abort_pins", {ss0, sclk0, busy0, done0, mosi0}, 5'b10000);
    check("abort_rx", rx0, 8'h00);
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done0) dn++;
    end
    rst0_n = 1'b1;
    repeat (DIV0 * 20) begin
      @(negedge clk);
      if (done0 || busy0) dn++;
    end
    check("abort_no_done", dn, 0);
    xfer0(8'hA5, 8'h00, 1'b1, 8'hA5, "after_reset", 1'b0);

    // Fast LSB-first instance.
    xfer1(8'h81, "div1_81");
    xfer1(8'h01, "div1_01");
    xfer1(8'h80, "div1_80");
    for (int i = 0; i < 3; i++) xfer1(DW'($urandom), $sformatf("div1_rand%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
